echo_meter: RTL and testbench

- Receive-side companion to the ultrasonic trigger generator.
- After a trigger is launched, waits for the sensor ECHO pulse, measures its high time in clock cycles and converts it to whole centimetres (floor of µs/58).
- Reports one result per measurement with a valid strobe, or a timeout when there is no echo or the echo is over range.
- Sits between the sensor ECHO pin and the display/control logic.

---
 rtl/echo_meter_pkg.sv | 26 ++
 rtl/echo_meter_if.sv | 15 +
 rtl/echo_sync_edge.sv | 30 +++
 rtl/echo_meter.sv | 134 +++++++++++++
 tb/tb_echo_meter.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/echo_meter_pkg.sv
// Shared types and defaults for the ultrasonic echo meter.
// Contents: FSM state encoding, default timing constants, clog2 helper.
package echo_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam int unsigned US_DIV_DEF         = 50;
  localparam int unsigned US_PER_CM_DEF      = 58;
  localparam int unsigned MAX_CM_DEF         = 400;
  localparam int unsigned ARM_TIMEOUT_US_DEF = 30000;
  localparam int unsigned DIST_W_DEF         = 9;

  // ceil(log2(v)), never less than 1 so every counter has at least one bit
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/echo_meter_if.sv
// Handshake bundle between trigger/control logic and the echo meter.
// start/ECHO flow into the meter; distance/valid/timeout/busy flow out.
interface echo_meter_if #(
  parameter int unsigned DIST_W = 9
);
  logic              start;
  logic              ECHO;
  logic [DIST_W-1:0] distance;
  logic              valid;
  logic              timeout;
  logic              busy;

  modport master (output start, ECHO, input distance, valid, timeout, busy);
  modport slave  (input start, ECHO, output distance, valid, timeout, busy);
endinterface

// File: rtl/echo_sync_edge.sv
// Two-flop synchroniser plus history flop for an asynchronous pin.
// Ports: clk, rst_n (async active-low), din (raw pin),
//        level (synchronised level), rise_c / fall_c (single-cycle edge flags).
module echo_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c
);
  logic s1, s2, s3;

  // metastability filter (s1, s2) and edge-detect history (s3)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level  = s2;
  assign rise_c = s2 & ~s3;
  assign fall_c = ~s2 & s3;
endmodule

// File: rtl/echo_meter.sv
// Ultrasonic echo meter: after start, waits for the ECHO pulse, times its
// high period and reports floor(us/US_PER_CM) centimetres, or a timeout.
// Ports: CLKOUT1 (clock), reset (async active-low),
//        bus.slave: start, ECHO in; distance, valid, timeout, busy out.
module echo_meter
  import echo_meter_pkg::*;
#(
  parameter int unsigned US_DIV         = US_DIV_DEF,
  parameter int unsigned US_PER_CM      = US_PER_CM_DEF,
  parameter int unsigned MAX_CM         = MAX_CM_DEF,
  parameter int unsigned ARM_TIMEOUT_US = ARM_TIMEOUT_US_DEF,
  parameter int unsigned DIST_W         = DIST_W_DEF
) (
  input  logic         CLKOUT1,
  input  logic         reset,
  echo_meter_if.slave  bus
);
  localparam int unsigned PRE_W = clog2(US_DIV);
  localparam int unsigned SUB_W = clog2(US_PER_CM);
  localparam int unsigned CM_W  = clog2(MAX_CM + 2);
  localparam int unsigned ARM_W = clog2(ARM_TIMEOUT_US + 1);

  state_t            state_q, state_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [SUB_W-1:0]  sub_q, sub_d;
  logic [CM_W-1:0]   cm_q, cm_d;
  logic [ARM_W-1:0]  arm_q, arm_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              tmo_q, tmo_d;
  logic              valid_q, busy_q;

  logic              rise, fall, unused_level;
  logic              pre_wrap, sub_wrap;
  logic [ARM_W-1:0]  arm_inc;

  // level output is not needed here; the block stays generic for other pins
  echo_sync_edge u_sync (
    .clk    (CLKOUT1),
    .rst_n  (reset),
    .din    (bus.ECHO),
    .level  (unused_level),
    .rise_c (rise),
    .fall_c (fall)
  );

  assign pre_wrap = (pre_q == PRE_W'(US_DIV - 1));
  assign sub_wrap = (sub_q == SUB_W'(US_PER_CM - 1));
  assign arm_inc  = arm_q + ARM_W'(1);

  // state, counters and registered outputs
  always_ff @(posedge CLKOUT1 or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pre_q   <= '0;
      sub_q   <= '0;
      cm_q    <= '0;
      arm_q   <= '0;
      dist_q  <= '0;
      tmo_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q   <= pre_d;
      sub_q   <= sub_d;
      cm_q    <= cm_d;
      arm_q   <= arm_d;
      dist_q  <= dist_d;
      tmo_q   <= tmo_d;
      valid_q <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
    end
  end

  // next-state and counter logic
  always_comb begin
    state_d = state_q;
    pre_d   = pre_q;
    sub_d   = sub_q;
    cm_d    = cm_q;
    arm_d   = arm_q;
    dist_d  = dist_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ARMED;
          pre_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
          arm_d   = '0;
        end
      end
      ARMED: begin
        pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
        if (pre_wrap) arm_d = arm_inc;
        // rise takes priority over an arm expiry in the same cycle
        if (rise) begin
          state_d = MEASURE;
          pre_d   = '0;
          sub_d   = '0;
          cm_d    = '0;
        end else if (pre_wrap && (arm_inc == ARM_W'(ARM_TIMEOUT_US))) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end
      end
      MEASURE: begin
        pre_d = pre_wrap ? '0 : pre_q + PRE_W'(1);
        if (pre_wrap) begin
          sub_d = sub_wrap ? '0 : sub_q + SUB_W'(1);
          if (sub_wrap) cm_d = cm_q + CM_W'(1);
        end
        // the fall cycle itself is counted, so the latched value uses cm_d
        if (cm_d == CM_W'(MAX_CM + 1)) begin
          state_d = DONE;
          tmo_d   = 1'b1;
        end else if (fall) begin
          state_d = DONE;
          tmo_d   = 1'b0;
          dist_d  = DIST_W'(cm_d);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.distance = dist_q;
  assign bus.valid    = valid_q;
  assign bus.timeout  = tmo_q;
  assign bus.busy     = busy_q;
endmodule

// File: tb/tb_echo_meter.sv
// Directed self-checking bench for echo_meter (6 clock cycles per cm).
module tb_echo_meter;
  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n;
  int   cnt_v, cnt_b;
  bit   seen;

  echo_meter_if #(.DIST_W(4)) bus ();

  echo_meter #(
    .US_DIV(2), .US_PER_CM(3), .MAX_CM(10), .ARM_TIMEOUT_US(20), .DIST_W(4)
  ) dut (
    .CLKOUT1 (clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int max, output int cycles, output bit got);
    got = 1'b0;
    cycles = 0;
    while (!got && cycles < max) begin
      tick();
      cycles++;
      if (bus.valid) got = 1'b1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // start, short arm wait, echo high for w cycles, then wait for the result
  task automatic run_echo(input int w, output int cycles, output bit got);
    pulse_start();
    repeat (3) tick();
    bus.ECHO = 1'b1;
    repeat (w) tick();
    bus.ECHO = 1'b0;
    wait_valid(20, cycles, got);
  endtask

  initial begin
    reset     = 1'b0;
    bus.start = 1'b0;
    bus.ECHO  = 1'b0;
    repeat (3) tick();
    check("rst_distance", int'(bus.distance), 0);
    check("rst_valid",    int'(bus.valid),    0);
    check("rst_timeout",  int'(bus.timeout),  0);
    check("rst_busy",     int'(bus.busy),     0);
    reset = 1'b1;
    tick();

    // 30-cycle echo -> 5 cm, valid 3 edges after ECHO sampled low
    pulse_start();
    check("armed_busy", int'(bus.busy), 1);
    repeat (3) tick();
    bus.ECHO = 1'b1;
    repeat (30) tick();
    bus.ECHO = 1'b0;
    wait_valid(20, n, seen);
    check("w30_seen",    int'(seen), 1);
    check("w30_latency", n, 3);
    check("w30_dist",    int'(bus.distance), 5);
    check("w30_tmo",     int'(bus.timeout),  0);
    check("w30_busy",    int'(bus.busy),     1);
    tick();
    check("w30_valid_1cyc", int'(bus.valid), 0);
    check("w30_busy_fall",  int'(bus.busy),  0);
    check("w30_dist_hold",  int'(bus.distance), 5);

    // floor boundary: 35 -> 5, 36 -> 6
    run_echo(35, n, seen);
    check("w35_seen", int'(seen), 1);
    check("w35_dist", int'(bus.distance), 5);
    tick();
    run_echo(36, n, seen);
    check("w36_seen", int'(seen), 1);
    check("w36_dist", int'(bus.distance), 6);
    check("w36_tmo",  int'(bus.timeout),  0);
    tick();

    // no echo: arm timeout after 40 cycles, distance held
    pulse_start();
    wait_valid(60, n, seen);
    check("arm_seen",   int'(seen), 1);
    check("arm_cycles", n, 40);
    check("arm_tmo",    int'(bus.timeout),  1);
    check("arm_dist",   int'(bus.distance), 6);
    tick();

    // echo held high: over range after 66 measured cycles
    pulse_start();
    repeat (2) tick();
    bus.ECHO = 1'b1;
    wait_valid(100, n, seen);
    check("ovr_seen",   int'(seen), 1);
    check("ovr_cycles", n, 69);
    check("ovr_tmo",    int'(bus.timeout),  1);
    check("ovr_dist",   int'(bus.distance), 6);
    tick();
    check("ovr_idle", int'(bus.busy), 0);
    // start during the pulse tail must wait for a fresh rise
    pulse_start();
    repeat (5) tick();
    bus.ECHO = 1'b0;
    check("tail_no_valid", int'(bus.valid), 0);
    check("tail_busy",     int'(bus.busy),  1);
    repeat (4) tick();
    bus.ECHO = 1'b1;
    repeat (12) tick();
    bus.ECHO = 1'b0;
    wait_valid(20, n, seen);
    check("w12_seen", int'(seen), 1);
    check("w12_dist", int'(bus.distance), 2);
    check("w12_tmo",  int'(bus.timeout),  0);
    tick();

    // reset mid-measurement clears outputs at once, no result follows
    pulse_start();
    tick();
    bus.ECHO = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("mid_rst_dist",  int'(bus.distance), 0);
    check("mid_rst_busy",  int'(bus.busy),     0);
    check("mid_rst_valid", int'(bus.valid),    0);
    bus.ECHO = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    cnt_v = 0;
    repeat (10) begin
      tick();
      if (bus.valid) cnt_v++;
    end
    check("post_rst_no_valid", cnt_v, 0);

    // extra start while measuring is ignored
    pulse_start();
    repeat (3) tick();
    bus.ECHO = 1'b1;
    repeat (10) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (13) tick();
    bus.ECHO = 1'b0;
    wait_valid(20, n, seen);
    check("w24_seen", int'(seen), 1);
    check("w24_dist", int'(bus.distance), 4);
    check("w24_tmo",  int'(bus.timeout),  0);
    // start coinciding with DONE is ignored
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_start_busy", int'(bus.busy), 0);
    tick();
    check("done_start_idle", int'(bus.busy), 0);

    // ECHO activity in IDLE without start
    cnt_v = 0;
    cnt_b = 0;
    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) bus.ECHO = ~bus.ECHO;
      tick();
      if (bus.valid) cnt_v++;
      if (bus.busy)  cnt_b++;
    end
    check("idle_echo_valid", cnt_v, 0);
    check("idle_echo_busy",  cnt_b, 0);
    check("idle_echo_dist",  int'(bus.distance), 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
